// File: rtl/arm_pkg.sv
// Shared ARM encodings for the decode stage: ALU commands, instruction fields,
// condition codes and status-bit positions.
package arm_pkg;

   localparam logic [3:0] ALU_MOV = 4'b0001;
   localparam logic [3:0] ALU_MVN = 4'b1001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_ADC = 4'b0011;
   localparam logic [3:0] ALU_SUB = 4'b0100;
   localparam logic [3:0] ALU_SBC = 4'b0101;
   localparam logic [3:0] ALU_AND = 4'b0110;
   localparam logic [3:0] ALU_ORR = 4'b0111;
   localparam logic [3:0] ALU_EOR = 4'b1000;

   localparam logic [1:0] MODE_DATA   = 2'b00;
   localparam logic [1:0] MODE_MEM    = 2'b01;
   localparam logic [1:0] MODE_BRANCH = 2'b10;

   localparam logic [3:0] OP_MOV = 4'b1101;
   localparam logic [3:0] OP_MVN = 4'b1111;
   localparam logic [3:0] OP_ADD = 4'b0100;
   localparam logic [3:0] OP_ADC = 4'b0101;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_SBC = 4'b0110;
   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_ORR = 4'b1100;
   localparam logic [3:0] OP_EOR = 4'b0001;
   localparam logic [3:0] OP_CMP = 4'b1010;
   localparam logic [3:0] OP_TST = 4'b1000;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;

   localparam int unsigned ST_N = 3;
   localparam int unsigned ST_Z = 2;
   localparam int unsigned ST_C = 1;
   localparam int unsigned ST_V = 0;

   typedef struct packed {
      logic [3:0] alu_cmd;
      logic       mem_read;
      logic       mem_write;
      logic       wb_en;
      logic       branch;
      logic       status_en;
   } ctrl_t;

endpackage

// File: rtl/id_stage_pipelined_if.sv
// Bus between the fetch/hazard/write-back side (master) and the decode stage (slave).
interface id_stage_pipelined_if #(
   parameter int DATA_W = 32,
   parameter int PC_W   = 32
);
   logic              freeze;
   logic              flush;
   logic              hazard;
   logic [PC_W-1:0]   pc_in;
   logic [31:0]       instruction;
   logic [3:0]        status;
   logic              wb_en;
   logic [3:0]        wb_dest;
   logic [DATA_W-1:0] wb_data;
   logic [3:0]        id_src1;
   logic [3:0]        id_src2;
   logic              id_two_src;
   logic              ex_valid;
   logic [PC_W-1:0]   ex_pc;
   logic [DATA_W-1:0] ex_reg1;
   logic [DATA_W-1:0] ex_reg2;
   logic [3:0]        ex_alu_cmd;
   logic              ex_mem_read;
   logic              ex_mem_write;
   logic              ex_wb_en;
   logic              ex_branch;
   logic              ex_status_en;
   logic              ex_imm;
   logic [3:0]        ex_dest;
   logic [3:0]        ex_src1;
   logic [3:0]        ex_src2;
   logic [23:0]       ex_imm24;
   logic [11:0]       ex_shift_op;

   modport master (
      output freeze, flush, hazard, pc_in, instruction, status, wb_en, wb_dest, wb_data,
      input  id_src1, id_src2, id_two_src, ex_valid, ex_pc, ex_reg1, ex_reg2, ex_alu_cmd,
             ex_mem_read, ex_mem_write, ex_wb_en, ex_branch, ex_status_en, ex_imm,
             ex_dest, ex_src1, ex_src2, ex_imm24, ex_shift_op
   );

   modport slave (
      input  freeze, flush, hazard, pc_in, instruction, status, wb_en, wb_dest, wb_data,
      output id_src1, id_src2, id_two_src, ex_valid, ex_pc, ex_reg1, ex_reg2, ex_alu_cmd,
             ex_mem_read, ex_mem_write, ex_wb_en, ex_branch, ex_status_en, ex_imm,
             ex_dest, ex_src1, ex_src2, ex_imm24, ex_shift_op
   );

endinterface

// File: rtl/register_file_bypass.sv
// Two-read / one-write register file; optional forwarding of a same-cycle write to the reads.
module register_file_bypass #(
   parameter int NUM_REGS  = 16,
   parameter int DATA_W    = 32,
   parameter int BYPASS_WB = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        rd_addr1_i,
   input  logic [3:0]        rd_addr2_i,
   output logic [DATA_W-1:0] rd_data1_o,
   output logic [DATA_W-1:0] rd_data2_o,
   input  logic              wr_en_i,
   input  logic [3:0]        wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i
);

   logic [DATA_W-1:0] regs_q [16];

   function automatic logic in_range(input logic [3:0] a);
      return int'({28'd0, a}) < NUM_REGS;
   endfunction

   function automatic logic fwd(input logic [3:0] a, input logic en, input logic [3:0] wa);
      return (BYPASS_WB != 0) && en && (wa == a);
   endfunction

   always_comb begin
      rd_data1_o = '0;
      rd_data2_o = '0;
      if (in_range(rd_addr1_i))
         rd_data1_o = fwd(rd_addr1_i, wr_en_i, wr_addr_i) ? wr_data_i : regs_q[rd_addr1_i];
      if (in_range(rd_addr2_i))
         rd_data2_o = fwd(rd_addr2_i, wr_en_i, wr_addr_i) ? wr_data_i : regs_q[rd_addr2_i];
   end

   // A write coinciding with reset is dropped along with everything else
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) regs_q[i] <= '0;
      end else if (wr_en_i && in_range(wr_addr_i)) begin
         regs_q[wr_addr_i] <= wr_data_i;
      end
   end

endmodule

// File: rtl/id_stage_pipelined.sv
// ARM decode stage: condition check, control decode, register read and the ID/EX register
// with freeze (hold), flush/hazard (bubble) handling.
module id_stage_pipelined
   import arm_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int PC_W      = 32,
   parameter int NUM_REGS  = 16,
   parameter int BYPASS_WB = 1
) (
   input logic                clk,
   input logic                rst,
   id_stage_pipelined_if.slave bus
);

   typedef struct packed {
      logic              valid;
      logic [PC_W-1:0]   pc;
      logic [DATA_W-1:0] reg1;
      logic [DATA_W-1:0] reg2;
      ctrl_t             ctrl;
      logic              imm;
      logic [3:0]        dest;
      logic [3:0]        src1;
      logic [3:0]        src2;
      logic [23:0]       imm24;
      logic [11:0]       shift_op;
   } ex_t;

   function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] st);
      logic n, z, c, v;
      n = st[ST_N];
      z = st[ST_Z];
      c = st[ST_C];
      v = st[ST_V];
      case (cond)
         COND_EQ: cond_pass = z;
         COND_NE: cond_pass = !z;
         COND_CS: cond_pass = c;
         COND_CC: cond_pass = !c;
         COND_MI: cond_pass = n;
         COND_PL: cond_pass = !n;
         COND_VS: cond_pass = v;
         COND_VC: cond_pass = !v;
         COND_HI: cond_pass = c && !z;
         COND_LS: cond_pass = !c || z;
         COND_GE: cond_pass = (n == v);
         COND_LT: cond_pass = (n != v);
         COND_GT: cond_pass = !z && (n == v);
         COND_LE: cond_pass = z || (n != v);
         COND_AL: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   endfunction

   function automatic ctrl_t decode(input logic [31:0] ins);
      ctrl_t c;
      c = '0;
      case (ins[27:26])
         MODE_DATA: begin
            c.wb_en     = 1'b1;
            c.status_en = ins[20];
            case (ins[24:21])
               OP_MOV:  c.alu_cmd = ALU_MOV;
               OP_MVN:  c.alu_cmd = ALU_MVN;
               OP_ADD:  c.alu_cmd = ALU_ADD;
               OP_ADC:  c.alu_cmd = ALU_ADC;
               OP_SUB:  c.alu_cmd = ALU_SUB;
               OP_SBC:  c.alu_cmd = ALU_SBC;
               OP_AND:  c.alu_cmd = ALU_AND;
               OP_ORR:  c.alu_cmd = ALU_ORR;
               OP_EOR:  c.alu_cmd = ALU_EOR;
               OP_CMP:  begin c.alu_cmd = ALU_SUB; c.wb_en = 1'b0; end
               OP_TST:  begin c.alu_cmd = ALU_AND; c.wb_en = 1'b0; end
               default: c = '0;
            endcase
         end
         MODE_MEM: begin
            c.alu_cmd = ALU_ADD;
            if (ins[20]) begin
               c.mem_read = 1'b1;
               c.wb_en    = 1'b1;
            end else begin
               c.mem_write = 1'b1;
            end
         end
         MODE_BRANCH: c.branch = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

   logic [31:0]       ins;
   logic              is_str;
   logic              bubble;
   logic [3:0]        src1;
   logic [3:0]        src2;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;
   ex_t               ex_d;
   ex_t               ex_q;

   assign ins    = bus.instruction;
   assign is_str = (ins[27:26] == MODE_MEM) && !ins[20];
   assign src1   = ins[19:16];
   // Stores read the data register Rd as their second operand
   assign src2   = is_str ? ins[15:12] : ins[3:0];
   assign bubble = !cond_pass(ins[31:28], bus.status) || bus.hazard || bus.flush ||
                   (ins == 32'd0);

   register_file_bypass #(
      .NUM_REGS (NUM_REGS),
      .DATA_W   (DATA_W),
      .BYPASS_WB(BYPASS_WB)
   ) u_rf (
      .clk       (clk),
      .rst       (rst),
      .rd_addr1_i(src1),
      .rd_addr2_i(src2),
      .rd_data1_o(rd1),
      .rd_data2_o(rd2),
      .wr_en_i   (bus.wb_en),
      .wr_addr_i (bus.wb_dest),
      .wr_data_i (bus.wb_data)
   );

   always_comb begin
      ex_d = ex_q;
      if (!bus.freeze) begin
         ex_d.valid    = !bubble;
         ex_d.pc       = bus.pc_in;
         ex_d.reg1     = rd1;
         ex_d.reg2     = rd2;
         ex_d.ctrl     = bubble ? ctrl_t'('0) : decode(ins);
         ex_d.imm      = !bubble && ins[25];
         ex_d.dest     = ins[15:12];
         ex_d.src1     = src1;
         ex_d.src2     = src2;
         ex_d.imm24    = ins[23:0];
         ex_d.shift_op = ins[11:0];
      end
   end

   // ID/EX boundary
   always_ff @(posedge clk) begin
      if (rst) ex_q <= '0;
      else     ex_q <= ex_d;
   end

   assign bus.id_src1      = src1;
   assign bus.id_src2      = src2;
   assign bus.id_two_src   = !ins[25] || is_str;
   assign bus.ex_valid     = ex_q.valid;
   assign bus.ex_pc        = ex_q.pc;
   assign bus.ex_reg1      = ex_q.reg1;
   assign bus.ex_reg2      = ex_q.reg2;
   assign bus.ex_alu_cmd   = ex_q.ctrl.alu_cmd;
   assign bus.ex_mem_read  = ex_q.ctrl.mem_read;
   assign bus.ex_mem_write = ex_q.ctrl.mem_write;
   assign bus.ex_wb_en     = ex_q.ctrl.wb_en;
   assign bus.ex_branch    = ex_q.ctrl.branch;
   assign bus.ex_status_en = ex_q.ctrl.status_en;
   assign bus.ex_imm       = ex_q.imm;
   assign bus.ex_dest      = ex_q.dest;
   assign bus.ex_src1      = ex_q.src1;
   assign bus.ex_src2      = ex_q.src2;
   assign bus.ex_imm24     = ex_q.imm24;
   assign bus.ex_shift_op  = ex_q.shift_op;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Directed bench for id_stage_pipelined: two instances (bypass on/off) driven identically,
// checked every cycle against a behavioural decode model plus hand-computed literals.
module tb_id_stage_pipelined;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] r1;
      logic [31:0] r2;
      logic [3:0]  alu;
      logic        mr;
      logic        mw;
      logic        wb;
      logic        br;
      logic        se;
      logic        imm;
      logic [3:0]  dest;
      logic [3:0]  s1;
      logic [3:0]  s2;
      logic [23:0] i24;
      logic [11:0] sh;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, freeze, flush, hazard, wb_en;
   logic [31:0] pc_in, instr, wb_data;
   logic [3:0]  status, wb_dest;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   id_stage_pipelined_if #(.DATA_W(32), .PC_W(32)) ifb ();
   id_stage_pipelined_if #(.DATA_W(32), .PC_W(32)) ifn ();

   assign ifb.freeze = freeze;  assign ifn.freeze = freeze;
   assign ifb.flush  = flush;   assign ifn.flush  = flush;
   assign ifb.hazard = hazard;  assign ifn.hazard = hazard;
   assign ifb.pc_in  = pc_in;   assign ifn.pc_in  = pc_in;
   assign ifb.instruction = instr;  assign ifn.instruction = instr;
   assign ifb.status  = status;  assign ifn.status  = status;
   assign ifb.wb_en   = wb_en;   assign ifn.wb_en   = wb_en;
   assign ifb.wb_dest = wb_dest; assign ifn.wb_dest = wb_dest;
   assign ifb.wb_data = wb_data; assign ifn.wb_data = wb_data;

   id_stage_pipelined #(.DATA_W(32), .PC_W(32), .NUM_REGS(16), .BYPASS_WB(1)) dut_b (
      .clk(clk), .rst(rst), .bus(ifb.slave));
   id_stage_pipelined #(.DATA_W(32), .PC_W(32), .NUM_REGS(16), .BYPASS_WB(0)) dut_n (
      .clk(clk), .rst(rst), .bus(ifn.slave));

   exp_t actb, actn;
   assign actb = {ifb.ex_valid, ifb.ex_pc, ifb.ex_reg1, ifb.ex_reg2, ifb.ex_alu_cmd,
                  ifb.ex_mem_read, ifb.ex_mem_write, ifb.ex_wb_en, ifb.ex_branch,
                  ifb.ex_status_en, ifb.ex_imm, ifb.ex_dest, ifb.ex_src1, ifb.ex_src2,
                  ifb.ex_imm24, ifb.ex_shift_op};
   assign actn = {ifn.ex_valid, ifn.ex_pc, ifn.ex_reg1, ifn.ex_reg2, ifn.ex_alu_cmd,
                  ifn.ex_mem_read, ifn.ex_mem_write, ifn.ex_wb_en, ifn.ex_branch,
                  ifn.ex_status_en, ifn.ex_imm, ifn.ex_dest, ifn.ex_src1, ifn.ex_src2,
                  ifn.ex_imm24, ifn.ex_shift_op};

   // ALU command per data-processing opcode; -1 marks opcodes the core does not implement
   int alu_tab [16] = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};

   logic [31:0] mregs [16];
   exp_t        expb, expn;
   bit          known   = 1'b0;
   bit          started = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ARM conditions come in complementary pairs; 1110 always runs, 1111 never does
   function automatic bit cond_ok(input logic [3:0] cond, input logic [3:0] st);
      bit n, z, c, v, base;
      n = st[3]; z = st[2]; c = st[1]; v = st[0];
      if (cond == 4'hE) return 1'b1;
      if (cond == 4'hF) return 1'b0;
      case (cond[3:1])
         3'd0: base = z;
         3'd1: base = c;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = c & ~z;
         3'd5: base = (n == v);
         default: base = ~z & (n == v);
      endcase
      return cond[0] ? !base : base;
   endfunction

   function automatic logic [31:0] rdreg(input logic [3:0] idx, input bit byp);
      if (byp && wb_en && wb_dest == idx) return wb_data;
      return mregs[idx];
   endfunction

   function automatic bit is_store();
      return instr[27:26] == 2'b01 && !instr[20];
   endfunction

   function automatic exp_t predict(input bit byp);
      exp_t e;
      bit   run;
      logic [3:0] s2;
      int   a;
      e   = '0;
      s2  = is_store() ? instr[15:12] : instr[3:0];
      run = cond_ok(instr[31:28], status) && !hazard && !flush && instr != 32'd0;
      e.valid = run;
      e.pc    = pc_in;
      e.r1    = rdreg(instr[19:16], byp);
      e.r2    = rdreg(s2, byp);
      e.dest  = instr[15:12];
      e.s1    = instr[19:16];
      e.s2    = s2;
      e.i24   = instr[23:0];
      e.sh    = instr[11:0];
      if (run) begin
         e.imm = instr[25];
         a = alu_tab[instr[24:21]];
         case (instr[27:26])
            2'b00: if (a >= 0) begin
               e.alu = 4'(a);
               e.se  = instr[20];
               e.wb  = !(instr[24:21] == 4'd10 || instr[24:21] == 4'd8);
            end
            2'b01: begin
               e.alu = 4'd2;
               e.mr  = instr[20];
               e.wb  = instr[20];
               e.mw  = !instr[20];
            end
            2'b10: e.br = 1'b1;
            default: ;
         endcase
      end
      return e;
   endfunction

   task automatic check_inst(input string tag, input exp_t e, input exp_t a, input bit k);
      chk({tag, ".valid"}, 32'(a.valid), 32'(e.valid));
      chk({tag, ".alu"}, 32'(a.alu), 32'(e.alu));
      chk({tag, ".ctl"}, 32'({a.mr, a.mw, a.wb, a.br, a.se, a.imm}),
          32'({e.mr, e.mw, e.wb, e.br, e.se, e.imm}));
      if (k) begin
         chk({tag, ".pc"}, a.pc, e.pc);
         chk({tag, ".reg1"}, a.r1, e.r1);
         chk({tag, ".reg2"}, a.r2, e.r2);
         chk({tag, ".fields"}, 32'({a.dest, a.s1, a.s2}), 32'({e.dest, e.s1, e.s2}));
         chk({tag, ".imm24"}, 32'(a.i24), 32'(e.i24));
         chk({tag, ".shift"}, 32'(a.sh), 32'(e.sh));
      end
   endtask

   always @(posedge clk) begin
      if (rst) begin
         started = 1'b1;
         known   = 1'b1;
         expb    = '0;
         expn    = '0;
         for (int i = 0; i < 16; i++) mregs[i] = '0;
      end else begin
         if (!freeze) begin
            expb  = predict(1'b1);
            expn  = predict(1'b0);
            known = expb.valid;
         end
         if (wb_en) mregs[wb_dest] = wb_data;
      end
      #2;
      if (started) begin
         check_inst("byp", expb, actb, known);
         check_inst("nobyp", expn, actn, known);
         chk("id_src1", 32'(ifb.id_src1), 32'(instr[19:16]));
         chk("id_src2", 32'(ifb.id_src2), 32'(is_store() ? instr[15:12] : instr[3:0]));
         chk("id_two_src", 32'(ifb.id_two_src), 32'(!instr[25] || is_store()));
      end
   end

   task automatic tick();
      @(negedge clk);
      pc_in = pc_in + 32'd4;
   endtask

   initial begin
      rst = 1'b1; freeze = 1'b0; flush = 1'b0; hazard = 1'b0;
      pc_in = 32'h1000; instr = 32'hE0821003; status = 4'h0;
      wb_en = 1'b0; wb_dest = 4'h0; wb_data = 32'h0;
      tick(); tick();
      chk("rst_valid", 32'(ifb.ex_valid), 32'd0);
      chk("rst_alu", 32'(ifb.ex_alu_cmd), 32'd0);
      chk("rst_wb", 32'(ifb.ex_wb_en), 32'd0);
      chk("rst_pc", ifb.ex_pc, 32'd0);

      // every register reads zero after reset
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         instr = 32'hE0800000 | (32'(i) << 16) | 32'(i);
         tick();
      end
      chk("r15_zero", ifb.ex_reg1, 32'd0);
      chk("r15_src1", 32'(ifb.ex_src1), 32'd15);

      instr = 32'h0; wb_en = 1'b1;
      wb_dest = 4'd2; wb_data = 32'd5;     tick();
      wb_dest = 4'd3; wb_data = 32'd7;     tick();
      wb_dest = 4'd4; wb_data = 32'h44;    tick();
      wb_dest = 4'd5; wb_data = 32'h100;   tick();
      wb_en = 1'b0;

      instr = 32'hE0821003; tick();
      chk("add_valid", 32'(ifb.ex_valid), 32'd1);
      chk("add_alu", 32'(ifb.ex_alu_cmd), 32'h2);
      chk("add_wb", 32'(ifb.ex_wb_en), 32'd1);
      chk("add_reg1", ifb.ex_reg1, 32'd5);
      chk("add_reg2", ifb.ex_reg2, 32'd7);
      chk("add_dest", 32'(ifb.ex_dest), 32'd1);

      wb_en = 1'b1; wb_dest = 4'd2; wb_data = 32'hAA; tick();
      chk("bypass_on", ifb.ex_reg1, 32'hAA);
      chk("bypass_off", ifn.ex_reg1, 32'd5);
      wb_en = 1'b0;

      instr = 32'h00821003; status = 4'b0000; tick();
      chk("addeq_z0", 32'(ifb.ex_valid), 32'd0);
      status = 4'b0100; tick();
      chk("addeq_z1", 32'(ifb.ex_valid), 32'd1);
      chk("addeq_reg1", ifn.ex_reg1, 32'hAA);
      instr = 32'hF0821003; tick();
      chk("cond_never", 32'(ifb.ex_valid), 32'd0);
      instr = 32'h0; tick();
      chk("instr_zero", 32'(ifb.ex_valid), 32'd0);

      status = 4'b0000; instr = 32'hE0821003; hazard = 1'b1; tick();
      chk("hazard_valid", 32'(ifb.ex_valid), 32'd0);
      chk("hazard_wb", 32'(ifb.ex_wb_en), 32'd0);
      flush = 1'b1; tick();
      chk("flush_hazard", 32'(ifb.ex_valid), 32'd0);
      hazard = 1'b0; flush = 1'b0; instr = 32'hE0526003; tick();
      chk("subs_alu", 32'(ifb.ex_alu_cmd), 32'h4);
      chk("subs_se", 32'(ifb.ex_status_en), 32'd1);

      // frozen register must ignore flush; write-back keeps going underneath
      freeze = 1'b1; flush = 1'b1; instr = 32'hE3A07012;
      wb_en = 1'b1; wb_dest = 4'd8; wb_data = 32'h88; tick();
      chk("freeze_alu", 32'(ifb.ex_alu_cmd), 32'h4);
      chk("freeze_dest", 32'(ifb.ex_dest), 32'd6);
      chk("freeze_valid", 32'(ifb.ex_valid), 32'd1);
      wb_en = 1'b0; tick();
      chk("freeze2_dest", 32'(ifb.ex_dest), 32'd6);
      freeze = 1'b0; flush = 1'b0; tick();
      chk("release_alu", 32'(ifb.ex_alu_cmd), 32'h1);
      chk("release_imm", 32'(ifb.ex_imm), 32'd1);
      chk("release_dest", 32'(ifb.ex_dest), 32'd7);
      instr = 32'hE0880008; tick();
      chk("freeze_write", ifb.ex_reg1, 32'h88);

      instr = 32'hE5854000; #1;
      chk("str_id_src2", 32'(ifb.id_src2), 32'd4);
      chk("str_two_src", 32'(ifb.id_two_src), 32'd1);
      tick();
      chk("str_mw", 32'(ifb.ex_mem_write), 32'd1);
      chk("str_wb", 32'(ifb.ex_wb_en), 32'd0);
      chk("str_reg2", ifb.ex_reg2, 32'h44);
      instr = 32'hE5959000; tick();
      chk("ldr_mr", 32'(ifb.ex_mem_read), 32'd1);
      chk("ldr_wb", 32'(ifb.ex_wb_en), 32'd1);

      for (int op = 0; op < 16; op++) begin
         instr = 32'hE0000000 | (32'(op) << 21) | (32'(op & 1) << 20) | 32'h00023004;
         tick();
      end
      instr = 32'hEA000010; tick();
      chk("branch", 32'(ifb.ex_branch), 32'd1);
      instr = 32'hEF000000; tick();
      instr = 32'hE2821005; tick();

      for (int s = 0; s < 16; s += 3) begin
         status = 4'(s);
         for (int c = 0; c < 16; c++) begin
            instr = (32'(c) << 28) | 32'h00821003;
            tick();
         end
      end
      status = 4'h0;

      instr = 32'hE0821003; wb_en = 1'b1; wb_dest = 4'd3; wb_data = 32'h1234; tick();
      chk("bypass_reg2", ifb.ex_reg2, 32'h1234);
      wb_en = 1'b0; tick();

      rst = 1'b1; wb_en = 1'b1; wb_dest = 4'd3; wb_data = 32'h33; tick();
      chk("midrst_valid", 32'(ifb.ex_valid), 32'd0);
      rst = 1'b0; wb_en = 1'b0; tick();
      chk("postrst_valid", 32'(ifb.ex_valid), 32'd1);
      chk("postrst_reg1", ifb.ex_reg1, 32'd0);
      chk("postrst_reg2", ifb.ex_reg2, 32'd0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
